uart_cmd_parser: RTL and testbench

//  Downstream consumer of the UART RX FIFO: pops received bytes, assembles CR-terminated ASCII command lines,

---
 rtl/uart_cmd_parser_pkg.sv | 30 +++
 rtl/uart_cmd_parser_hex_ascii_codec.sv | 30 +++
 rtl/uart_cmd_parser.sv | 188 ++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_parser_pkg.sv
// Shared types and ASCII constants for the UART command-line parser.
package uart_cmd_parser_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_GAP,
    S_ECHO,
    S_PARSE,
    S_RESP
  } state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_O  = 8'h4F;
  localparam logic [7:0] ASCII_K  = 8'h4B;
  localparam logic [7:0] ASCII_E  = 8'h45;
  localparam logic [7:0] ASCII_R  = 8'h52;

  localparam logic [31:0] CMD_TEST = "TEST";
  localparam logic [31:0] CMD_RDLD = "RDLD";
  localparam logic [15:0] CMD_LD   = "LD";

  localparam logic [15:0] REPLY_EOL = {ASCII_CR, ASCII_LF};
  localparam logic [31:0] REPLY_OK  = {ASCII_O, ASCII_K, ASCII_CR, ASCII_LF};
  localparam logic [31:0] REPLY_ER  = {ASCII_E, ASCII_R, ASCII_CR, ASCII_LF};

  // Largest value accepted by the LD command (6-bit LED register).
  localparam logic [7:0] LED_MAX = 8'h3F;

endpackage

// File: rtl/uart_cmd_parser_hex_ascii_codec.sv
// Combinational uppercase-hex ASCII <-> nibble converter.
// Decode path flags anything other than '0'-'9' / 'A'-'F' as invalid.
module hex_ascii_codec (
  input  logic [7:0] ascii_i,
  output logic [3:0] nibble_o,
  output logic       valid_o,
  input  logic [3:0] nibble_i,
  output logic [7:0] ascii_o
);

  // ASCII character to nibble, uppercase only
  always_comb begin
    nibble_o = '0;
    valid_o  = 1'b0;
    if (ascii_i >= 8'h30 && ascii_i <= 8'h39) begin
      nibble_o = ascii_i[3:0];
      valid_o  = 1'b1;
    end else if (ascii_i >= 8'h41 && ascii_i <= 8'h46) begin
      nibble_o = ascii_i[3:0] + 4'd9;
      valid_o  = 1'b1;
    end
  end

  // Nibble to uppercase ASCII hex digit
  always_comb begin
    if (nibble_i < 4'd10) ascii_o = 8'h30 + {4'h0, nibble_i};
    else                  ascii_o = 8'h37 + {4'h0, nibble_i};
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// UART command-line parser: pops RX FIFO bytes, assembles CR-terminated
// 4-byte commands (TEST, LDhh, RDLD), drives the LED register and writes a
// 4-byte reply into the TX FIFO.
// Optional build macro: UART_CMD_PARSER_ECHO_EN (echo received command bytes).
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int         CMD_LENGTH = 4,
  parameter logic [7:0] TERM_CHAR  = 8'h0D,
  parameter logic [5:0] LED_RESET  = 6'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_fifo_empty,
  input  logic [7:0] rx_fifo_data_out,
  output logic       rx_fifo_read_en,
  input  logic       tx_fifo_full,
  output logic [7:0] tx_fifo_data_in,
  output logic       tx_fifo_write_en,
  output logic [5:0] led_value,
  output logic       cmd_strobe,
  output logic       cmd_error
);

  localparam logic [2:0] CMD_LEN = 3'(CMD_LENGTH);

  state_t      state_q;
  logic [7:0]  byte_q;
  logic [7:0]  buf_q [4];
  logic [2:0]  idx_q;
  logic        ovf_q;
  logic [31:0] resp_q;
  logic [1:0]  ridx_q;
  logic        rd_q;
  logic [5:0]  led_q;
  logic        strobe_q;
  logic        error_q;

  logic [31:0] line_w;
  logic [3:0]  hi_nib, lo_nib;
  logic        hi_valid, lo_valid;
  logic [7:0]  enc_hi, enc_lo;
  logic [7:0]  ld_value;

  logic [31:0] reply_d;
  logic        ok_d;
  logic        led_wr_d;

  assign line_w   = {buf_q[0], buf_q[1], buf_q[2], buf_q[3]};
  assign ld_value = {hi_nib, lo_nib};

  // High digit: decodes LD argument h1, encodes upper LED nibble for RDLD
  hex_ascii_codec u_codec_hi (
    .ascii_i  (buf_q[2]),
    .nibble_o (hi_nib),
    .valid_o  (hi_valid),
    .nibble_i ({2'b00, led_q[5:4]}),
    .ascii_o  (enc_hi)
  );

  // Low digit: decodes LD argument h0, encodes lower LED nibble for RDLD
  hex_ascii_codec u_codec_lo (
    .ascii_i  (buf_q[3]),
    .nibble_o (lo_nib),
    .valid_o  (lo_valid),
    .nibble_i (led_q[3:0]),
    .ascii_o  (enc_lo)
  );

  // Command decode of the assembled line; consumed in S_PARSE
  always_comb begin
    reply_d  = REPLY_ER;
    ok_d     = 1'b0;
    led_wr_d = 1'b0;
    if (!ovf_q && idx_q == CMD_LEN) begin
      if (line_w == CMD_TEST) begin
        reply_d = REPLY_OK;
        ok_d    = 1'b1;
      end else if (line_w == CMD_RDLD) begin
        reply_d = {enc_hi, enc_lo, REPLY_EOL};
        ok_d    = 1'b1;
      end else if (line_w[31:16] == CMD_LD && hi_valid && lo_valid &&
                   ld_value <= LED_MAX) begin
        reply_d  = REPLY_OK;
        ok_d     = 1'b1;
        led_wr_d = 1'b1;
      end
    end
  end

  // TX push: reply bytes from the head of the reply shift register, or the echoed byte
  always_comb begin
    tx_fifo_write_en = 1'b0;
    tx_fifo_data_in  = '0;
    if (!reset && !tx_fifo_full) begin
      if (state_q == S_RESP) begin
        tx_fifo_write_en = 1'b1;
        tx_fifo_data_in  = resp_q[31:24];
      end
`ifdef UART_CMD_PARSER_ECHO_EN
      else if (state_q == S_ECHO) begin
        tx_fifo_write_en = 1'b1;
        tx_fifo_data_in  = byte_q;
      end
`endif
    end
  end

  // Main FSM: byte intake, line assembly, parse and reply sequencing
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_WAIT;
      byte_q   <= '0;
      idx_q    <= '0;
      ovf_q    <= 1'b0;
      resp_q   <= '0;
      ridx_q   <= '0;
      rd_q     <= 1'b0;
      led_q    <= LED_RESET;
      strobe_q <= 1'b0;
      error_q  <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) buf_q[i] <= '0;
    end else begin
      rd_q     <= 1'b0;
      strobe_q <= 1'b0;
      error_q  <= 1'b0;
      unique case (state_q)
        S_WAIT: begin
          if (!rx_fifo_empty) begin
            byte_q  <= rx_fifo_data_out;
            rd_q    <= 1'b1;
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          state_q <= S_WAIT;
          if (byte_q == TERM_CHAR) begin
            state_q <= S_PARSE;
          end else if (byte_q != ASCII_LF) begin
            if (idx_q < CMD_LEN) begin
              buf_q[idx_q[1:0]] <= byte_q;
              idx_q             <= idx_q + 3'd1;
            end else begin
              ovf_q <= 1'b1;
            end
`ifdef UART_CMD_PARSER_ECHO_EN
            state_q <= S_ECHO;
`endif
          end
        end
`ifdef UART_CMD_PARSER_ECHO_EN
        S_ECHO: begin
          if (!tx_fifo_full) state_q <= S_WAIT;
        end
`endif
        S_PARSE: begin
          idx_q <= '0;
          ovf_q <= 1'b0;
          if (idx_q == '0 && !ovf_q) begin
            state_q <= S_WAIT;
          end else begin
            resp_q   <= reply_d;
            ridx_q   <= '0;
            strobe_q <= ok_d;
            error_q  <= !ok_d;
            if (led_wr_d) led_q <= ld_value[5:0];
            state_q  <= S_RESP;
          end
        end
        S_RESP: begin
          // Reply is shifted out MSB-first; ridx_q counts bytes sent
          if (!tx_fifo_full) begin
            resp_q <= {resp_q[23:0], 8'h00};
            ridx_q <= ridx_q + 2'd1;
            if (ridx_q == 2'd3) state_q <= S_WAIT;
          end
        end
        default: state_q <= S_WAIT;
      endcase
    end
  end

  assign rx_fifo_read_en = rd_q;
  assign led_value       = led_q;
  assign cmd_strobe      = strobe_q;
  assign cmd_error       = error_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed scoreboard bench for uart_cmd_parser with FWFT RX FIFO model.
module tb_uart_cmd_parser;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx_fifo_empty = 1'b1;
  logic [7:0] rx_fifo_data_out = 8'h00;
  logic       rx_fifo_read_en;
  logic       tx_fifo_full = 1'b0;
  logic [7:0] tx_fifo_data_in;
  logic       tx_fifo_write_en;
  logic [5:0] led_value;
  logic       cmd_strobe;
  logic       cmd_error;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int tx_cnt = 0;
  int strobe_cnt = 0;
  int error_cnt = 0;
  int wwf = 0;
  int pop_empty = 0;
  int cr_pop_cyc = 0;
  int last_lat = -1;
  bit lat_armed = 1'b0;
  logic [7:0] mon_b;

  uart_cmd_parser #(
    .CMD_LENGTH (4),
    .TERM_CHAR  (8'h0D),
    .LED_RESET  (6'h00)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .rx_fifo_empty    (rx_fifo_empty),
    .rx_fifo_data_out (rx_fifo_data_out),
    .rx_fifo_read_en  (rx_fifo_read_en),
    .tx_fifo_full     (tx_fifo_full),
    .tx_fifo_data_in  (tx_fifo_data_in),
    .tx_fifo_write_en (tx_fifo_write_en),
    .led_value        (led_value),
    .cmd_strobe       (cmd_strobe),
    .cmd_error        (cmd_error)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Monitor on the falling edge: FIFO models, TX capture, pulse counting
  always @(negedge clock) begin
    cyc++;
    if (rx_fifo_read_en) begin
      if (rx_q.size() > 0) begin
        mon_b = rx_q.pop_front();
        if (mon_b == 8'h0D) begin
          cr_pop_cyc = cyc;
          lat_armed  = 1'b1;
        end
      end else begin
        pop_empty++;
      end
    end
    if (tx_fifo_write_en) begin
      obs_q.push_back(tx_fifo_data_in);
      tx_cnt++;
      if (tx_fifo_full) wwf++;
      if (lat_armed) begin
        last_lat  = cyc - cr_pop_cyc;
        lat_armed = 1'b0;
      end
    end
    if (cmd_strobe) strobe_cnt++;
    if (cmd_error)  error_cnt++;
    rx_fifo_empty    = (rx_q.size() == 0);
    rx_fifo_data_out = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push a command (CR appended); echoed bytes are expected in echo builds
  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++) begin
      rx_q.push_back(s[i]);
`ifdef UART_CMD_PARSER_ECHO_EN
      exp_q.push_back(s[i]);
`endif
    end
    rx_q.push_back(8'h0D);
  endtask

  // Expect a two-character reply followed by CR LF
  task automatic expect_reply(input string r);
    exp_q.push_back(r[0]);
    exp_q.push_back(r[1]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((rx_q.size() != 0 || obs_q.size() < exp_q.size()) && n < 3000) begin
      @(posedge clock);
      n++;
    end
    repeat (12) @(posedge clock);
    check({tag, " timeout"}, 32'(n < 3000), 32'd1);
    check({tag, " count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check({tag, " byte"}, {24'h0, obs_q.pop_front()}, {24'h0, exp_q.pop_front()});
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " read_en"},  32'(rx_fifo_read_en),  32'd0);
    check({tag, " write_en"}, 32'(tx_fifo_write_en), 32'd0);
    check({tag, " tx_data"},  32'(tx_fifo_data_in),  32'd0);
    check({tag, " strobe"},   32'(cmd_strobe),       32'd0);
    check({tag, " error"},    32'(cmd_error),        32'd0);
    check({tag, " led"},      32'(led_value),        32'h00);
  endtask

  initial begin
    int s0, e0, t0, n;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // 1: TEST -> OK, one strobe, two-cycle latency from CR pop
    s0 = strobe_cnt; e0 = error_cnt;
    send_line("TEST");
    expect_reply("OK");
    drain("test");
    check("test strobe", strobe_cnt - s0, 1);
    check("test no error", error_cnt - e0, 0);
    check("test latency", last_lat, 2);

    // 2: LD2A then RDLD
    s0 = strobe_cnt;
    send_line("LD2A");
    expect_reply("OK");
    send_line("RDLD");
    expect_reply("2A");
    drain("ld_rdld");
    check("ld led", 32'(led_value), 32'h2A);
    check("ld strobes", strobe_cnt - s0, 2);

    // 3: out-of-range, lowercase, overflow, short line -> ER, LED kept
    s0 = strobe_cnt; e0 = error_cnt;
    send_line("LD40");
    expect_reply("ER");
    send_line("ld1f");
    expect_reply("ER");
    send_line("TESTX");
    expect_reply("ER");
    send_line("LD");
    expect_reply("ER");
    drain("errors");
    check("err pulses", error_cnt - e0, 4);
    check("err no strobe", strobe_cnt - s0, 0);
    check("err led kept", 32'(led_value), 32'h2A);

    // Boundary: LD3F accepted, read back
    send_line("LD3F");
    expect_reply("OK");
    send_line("RDLD");
    expect_reply("3F");
    drain("ld3f");
    check("ld3f led", 32'(led_value), 32'h3F);

    // 4: TX full stalls the reply
    tx_fifo_full = 1'b1;
    t0 = tx_cnt;
    send_line("TEST");
    expect_reply("OK");
    n = 0;
    while (rx_q.size() != 0 && n < 40) begin
      @(posedge clock);
      n++;
    end
    repeat (10) @(posedge clock);
    #1;
    check("full no writes", tx_cnt - t0, 0);
    tx_fifo_full = 1'b0;
    drain("full");

    // 6: CR LF terminated line, then bare CR
    s0 = strobe_cnt; e0 = error_cnt;
    send_line("TEST");
    rx_q.push_back(8'h0A);
    expect_reply("OK");
    drain("crlf");
    check("crlf strobe", strobe_cnt - s0, 1);
    s0 = strobe_cnt; e0 = error_cnt;
    rx_q.push_back(8'h0D);
    drain("empty line");
    check("empty strobe", strobe_cnt - s0, 0);
    check("empty error", error_cnt - e0, 0);

    // 5: reset mid-reply and mid-line
    t0 = tx_cnt;
    send_line("TEST");
    expect_reply("OK");
    n = 0;
    while (tx_cnt < t0 + 2 + exp_q.size() - 4 && n < 200) begin
      @(posedge clock);
      n++;
    end
    #1;
    reset = 1'b1;
    while (exp_q.size() > 0 && exp_q.size() > obs_q.size()) void'(exp_q.pop_back());
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("midreply reset");
    reset = 1'b0;
    drain("midreply");

    rx_q.push_back("T");
    rx_q.push_back("E");
`ifdef UART_CMD_PARSER_ECHO_EN
    exp_q.push_back("T");
    exp_q.push_back("E");
`endif
    drain("partial");
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("midline reset");
    reset = 1'b0;
    s0 = strobe_cnt; e0 = error_cnt;
    send_line("TEST");
    expect_reply("OK");
    drain("after reset");
    check("after reset strobe", strobe_cnt - s0, 1);
    check("after reset error", error_cnt - e0, 0);

    check("write while full", wwf, 0);
    check("pop while empty", pop_empty, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
